// File: rtl/if_id_queue_pkg.sv
// Shared CPU definitions for the fetch/decode boundary: word width, NOP encoding,
// the IF/ID entry payload and the queue occupancy states.
package if_id_queue_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Payload carried from fetch to decode; the decode-stage register reuses it.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] baddr;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH words of ENTRY_W bits,
// one synchronous write port and one asynchronous read port.
module if_id_queue_mem #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRY_W = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Contents are only cleared by reset; pops and flushes leave them in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshakes on both sides
// and a flush that discards every buffered wrong-path entry.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_pc,
    input  logic [W-1:0]           in_instr,
    input  logic [W-1:0]           in_baddr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_pc,
    output logic [W-1:0]           out_instr,
    output logic [W-1:0]           out_baddr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned ENTRY_W = 3 * W;

    logic [AW-1:0]      wptr_q, wptr_nxt;
    logic [AW-1:0]      rptr_q, rptr_nxt;
    logic [CW-1:0]      count_q, count_nxt;
    occ_state_e         state_q, state_nxt;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Next pointers, occupancy and state; flush overrides any same-cycle push/pop.
    always_comb begin
        wptr_nxt  = wptr_q;
        rptr_nxt  = rptr_q;
        count_nxt = count_q;
        state_nxt = state_q;
        if (flush) begin
            wptr_nxt  = '0;
            rptr_nxt  = '0;
            count_nxt = '0;
            state_nxt = OCC_EMPTY;
        end else begin
            if (push) wptr_nxt = wptr_q + AW'(1);
            if (pop)  rptr_nxt = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_nxt = count_q + CW'(1);
                2'b01:   count_nxt = count_q - CW'(1);
                default: count_nxt = count_q;
            endcase
            if (count_nxt == '0)               state_nxt = OCC_EMPTY;
            else if (count_nxt == CW'(DEPTH))  state_nxt = OCC_FULL;
            else                               state_nxt = OCC_PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= OCC_EMPTY;
        end else begin
            wptr_q  <= wptr_nxt;
            rptr_q  <= rptr_nxt;
            count_q <= count_nxt;
            state_q <= state_nxt;
        end
    end

    if_id_queue_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wptr_q),
        .wdata ({in_pc, in_instr, in_baddr}),
        .raddr (rptr_q),
        .rdata (head)
    );

    // Handshake flags decode the registered occupancy state only.
    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign count     = count_q;

    // An empty queue presents a bubble to decode.
    assign out_pc    = out_valid ? head[ENTRY_W-1 -: W] : '0;
    assign out_instr = out_valid ? head[2*W-1 -: W]     : W'(NOP_INSTR);
    assign out_baddr = out_valid ? head[W-1:0]          : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed checks of the IF/ID queue: reset, fill/refuse, drain with throughput,
// latency, flush, pointer wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_pc;
    logic [W-1:0]  in_instr;
    logic [W-1:0]  in_baddr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_instr;
    logic [W-1:0]  out_baddr;
    logic [2:0]    count;

    int checks;
    int errors;

    if_id_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_baddr  (in_baddr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_baddr (out_baddr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus: instr and baddr are derived from the PC so each field is traceable.
    task automatic drive(input logic v, input logic [W-1:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = 32'hA000_0000 | pc;
        in_baddr  = pc + 32'h100;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h expected 0", out_instr); end
        checks++; if (out_pc !== 32'h0 || out_baddr !== 32'h0) begin errors++; $display("FAIL reset_out_pc_baddr got %h/%h expected 0/0", out_pc, out_baddr); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(k * 4), 1'b0, 1'b0);
            tick();
            checks++; if (count !== 3'(k + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d expected %0d", k, count, k + 1); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b expected 0", in_ready); end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL refused_push_count got %0d expected 4", count); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc got %h expected 0", out_pc); end
    endtask

    task automatic test_drain_throughput();
        logic [W-1:0] exp_pc;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 0) ? 32'h10 : 32'(32'h10 + 4 * (i - 1)), 1'b1, 1'b0);
            exp_pc = 32'(4 * i);
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_head_pc[%0d] got %h expected %h", i, out_pc, exp_pc); end
            checks++; if (in_ready !== (i != 0)) begin errors++; $display("FAIL stream_in_ready[%0d] got %b expected %b", i, in_ready, i != 0); end
            tick();
            checks++; if (count !== 3'd3) begin errors++; $display("FAIL stream_count[%0d] got %0d expected 3", i, count); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            exp_pc = 32'(32'h20 + 4 * i);
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL drain_head_pc[%0d] got %h expected %h", i, out_pc, exp_pc); end
            checks++; if (out_instr !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL drain_head_instr[%0d] got %h expected %h", i, out_instr, 32'hA000_0000 | exp_pc); end
            checks++; if (out_baddr !== exp_pc + 32'h100) begin errors++; $display("FAIL drain_head_baddr[%0d] got %h expected %h", i, out_baddr, exp_pc + 32'h100); end
            tick();
        end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drained_empty got count=%0d valid=%b expected 0/0", count, out_valid); end
    endtask

    task automatic test_latency();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        in_instr = 32'h2108_0001;
        #1;
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL latency_no_bypass got valid=%b instr=%h expected 0/0", out_valid, out_instr); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_out_valid got %b expected 1", out_valid); end
        checks++; if (out_instr !== 32'h2108_0001) begin errors++; $display("FAIL latency_out_instr got %h expected 21080001", out_instr); end
        checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL latency_out_pc got %h expected 10", out_pc); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL latency_pop_count got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(32'h200 + 4 * k), 1'b0, 1'b0);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d expected 3", count); end
        drive(1'b1, 32'h20C, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL flush_outputs got valid=%b instr=%h expected 0/0", out_valid, out_instr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b expected 1", in_ready); end
        tick();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_entry got count=%0d valid=%b expected 0/0", count, out_valid); end
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        checks++; if (out_pc !== 32'h300 || count !== 3'd1) begin errors++; $display("FAIL flush_refill got pc=%h count=%0d expected 300/1", out_pc, count); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_pc;
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'(32'h100 + 4 * k), 1'b1, 1'b0);
            exp_pc = 32'(32'h100 + 4 * (k - 1));
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL wrap_head_pc[%0d] got %h expected %h", k, out_pc, exp_pc); end
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d expected 1", k, count); end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_pc !== 32'h128) begin errors++; $display("FAIL wrap_last_pc got %h expected 128", out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'(32'h400 + 4 * k), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre_count got %0d expected 2", count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_flags got count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready); end
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_baddr !== 32'h0) begin errors++; $display("FAIL areset_data got %h/%h/%h expected 0/0/0", out_pc, out_instr, out_baddr); end
        #2 rst = 1'b1;
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_release_valid got %b expected 0", out_valid); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h500) begin errors++; $display("FAIL areset_first_push got valid=%b pc=%h expected 1/500", out_valid, out_pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        test_reset();
        #11 rst = 1'b1;
        tick();
        test_reset();
        test_fill();
        test_drain_throughput();
        test_latency();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
